cmd_frontend: RTL

CMD_FRONTEND -- requirements
Module: cmd_frontend

---
 rtl/cmd_frontend_pkg.sv | 52 +++++
 rtl/cmd_frontend_burst_addr_gen.sv | 73 +++++++
 rtl/cmd_frontend.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cmd_frontend_pkg.sv
// cmd_frontend_pkg
//   Shared definitions for the DDR4 command front-end:
//   - bit positions of the 19-entry one-hot command vector
//   - front-end state encoding
//   - default geometry (row width, bank-group/bank widths, columns, burst length)
//   - helper that builds a one-hot command vector from a bit index
package cmd_frontend_pkg;

  localparam int NUM_CMDS = 19;

  localparam int CMD_WRA   = 0;
  localparam int CMD_WR    = 1;
  localparam int CMD_WRAS4 = 2;
  localparam int CMD_WRS4  = 3;
  localparam int CMD_RDA   = 4;
  localparam int CMD_RD    = 5;
  localparam int CMD_RDAS4 = 6;
  localparam int CMD_PRE   = 7;
  localparam int CMD_PREA  = 8;
  localparam int CMD_MRS   = 9;
  localparam int CMD_REF   = 10;
  localparam int CMD_SRE   = 11;
  localparam int CMD_SRX   = 12;
  localparam int CMD_PDE   = 13;
  localparam int CMD_PDX   = 14;
  localparam int CMD_ZQCL  = 15;
  localparam int CMD_ZQCS  = 16;
  localparam int CMD_NOP   = 17;
  localparam int CMD_ACT   = 18;

  localparam int DEF_ADDRWIDTH = 17;
  localparam int DEF_BGWIDTH   = 2;
  localparam int DEF_BAWIDTH   = 2;
  localparam int DEF_COLS      = 1024;
  localparam int DEF_BL        = 8;

  typedef logic [NUM_CMDS-1:0] cmd_vec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST   = 2'd1,
    AUTOPRE = 2'd2
  } state_t;

  function automatic cmd_vec_t cmd_onehot(input int idx);
    cmd_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/cmd_frontend_burst_addr_gen.sv
// burst_addr_gen
//   Beat counter and per-beat column generator for RD/WR bursts.
//   A load captures the starting column and burst mode; each advance steps
//   one beat, wrapping the low column bits in sequential burst order
//   (mod BL for a full burst, mod 4 inside the aligned quad for BC4).
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   halt           freezes all internal state
//   load           start a burst at start_col (bc4 selects the chopped length)
//   advance        step to the next beat
//   start_col      beat-0 column
//   column         registered column of the current beat
//   last           current beat is the final beat of the burst
module burst_addr_gen
  import cmd_frontend_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int BL   = DEF_BL
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      halt,
  input  logic                      load,
  input  logic                      advance,
  input  logic                      bc4,
  input  logic [$clog2(COLS)-1:0]   start_col,
  output logic [$clog2(COLS)-1:0]   column,
  output logic                      last
);

  localparam int CW = $clog2(COLS);
  localparam int BW = $clog2(BL);

  logic [CW-1:0] base_q;
  logic [BW-1:0] beat_q;
  logic [BW-1:0] beat_n;
  logic          bc4_q;
  logic [CW-1:0] col_next;

  assign beat_n = beat_q + BW'(1);
  assign last   = (beat_q == (bc4_q ? BW'(3) : BW'(BL-1)));

  // Only the low bits of the start column rotate; the upper bits stay fixed
  // so the burst never leaves its aligned block.
  always_comb begin
    col_next = base_q;
    if (bc4_q) begin
      col_next[1:0] = base_q[1:0] + beat_n[1:0];
    end else begin
      col_next[BW-1:0] = base_q[BW-1:0] + beat_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q <= '0;
      beat_q <= '0;
      bc4_q  <= 1'b0;
      column <= '0;
    end else if (!halt) begin
      if (load) begin
        base_q <= start_col;
        beat_q <= '0;
        bc4_q  <= bc4;
        column <= start_col;
      end else if (advance) begin
        beat_q <= beat_n;
        column <= col_next;
      end
    end
  end

endmodule

// File: rtl/cmd_frontend.sv
// cmd_frontend
//   DDR4 command-pin decoder feeding a bank group. Pins are sampled every
//   non-halted cycle and turned into a registered one-hot command vector.
//   RD/WR hold their command bit for the whole burst while the column steps
//   per beat; an auto-precharge burst ends with a single PRE pulse. Commands
//   arriving during a burst are discarded and flagged on cmd_drop. CKE edges
//   produce self-refresh / power-down entry and exit commands.
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   cs_n act_n ras_n cas_n we_n    command pins (ras/cas/we are A16..A14 on ACT)
//   cke                            clock enable pin
//   bg_in, ba_in, a                bank group, bank and address pins
//   halt                           freeze everything, ignore pins
//   commands                       one-hot command vector
//   bg, ba, row, column            registered target address
//   busy                           burst or auto-precharge in progress
//   cmd_drop                       one-cycle pulse on a discarded command
module cmd_frontend
  import cmd_frontend_pkg::*;
#(
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int BGWIDTH   = DEF_BGWIDTH,
  parameter int BAWIDTH   = DEF_BAWIDTH,
  parameter int COLS      = DEF_COLS,
  parameter int BL        = DEF_BL
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs_n,
  input  logic                     act_n,
  input  logic                     ras_n,
  input  logic                     cas_n,
  input  logic                     we_n,
  input  logic                     cke,
  input  logic [BGWIDTH-1:0]       bg_in,
  input  logic [BAWIDTH-1:0]       ba_in,
  input  logic [13:0]              a,
  input  logic                     halt,
  output logic [NUM_CMDS-1:0]      commands,
  output logic [BGWIDTH-1:0]       bg,
  output logic [BAWIDTH-1:0]       ba,
  output logic [ADDRWIDTH-1:0]     row,
  output logic [$clog2(COLS)-1:0]  column,
  output logic                     busy,
  output logic                     cmd_drop
);

  state_t   state;
  logic     cke_q;
  logic     sr_latched;
  logic     ap_q;

  logic [2:0]  rcw;
  logic [16:0] act_addr;
  logic        bc4;
  cmd_vec_t    dec_cmd;
  logic        dec_valid;
  logic        dec_rdwr;
  logic        dec_ref;
  logic        dec_act;
  logic        cke_fall;
  logic        cke_rise;
  logic        burst_load;
  logic        burst_adv;
  logic        burst_last;

  assign rcw      = {ras_n, cas_n, we_n};
  assign act_addr = {ras_n, cas_n, we_n, a};
  assign bc4      = ~a[12];
  assign cke_fall = cke_q & ~cke;
  assign cke_rise = ~cke_q & cke;

  // Pin decode. dec_valid marks a real command (not DES/NOP); only those
  // update the bank target or count as drops while busy.
  always_comb begin
    dec_cmd   = '0;
    dec_valid = 1'b0;
    dec_rdwr  = 1'b0;
    dec_ref   = 1'b0;
    dec_act   = 1'b0;
    if (!cs_n) begin
      dec_valid = 1'b1;
      if (!act_n) begin
        dec_cmd = cmd_onehot(CMD_ACT);
        dec_act = 1'b1;
      end else begin
        case (rcw)
          3'b000: dec_cmd = cmd_onehot(CMD_MRS);
          3'b001: begin
            dec_cmd = cmd_onehot(CMD_REF);
            dec_ref = 1'b1;
          end
          3'b010: dec_cmd = a[10] ? cmd_onehot(CMD_PREA) : cmd_onehot(CMD_PRE);
          3'b100: begin
            dec_rdwr = 1'b1;
            if (bc4) dec_cmd = a[10] ? cmd_onehot(CMD_WRAS4) : cmd_onehot(CMD_WRS4);
            else     dec_cmd = a[10] ? cmd_onehot(CMD_WRA)   : cmd_onehot(CMD_WR);
          end
          3'b101: begin
            // A chopped read keeps its plain RD bit; only the auto-precharge
            // form carries the extra RDAS4 flag alongside RDA.
            dec_rdwr = 1'b1;
            if (a[10]) dec_cmd = bc4 ? (cmd_onehot(CMD_RDA) | cmd_onehot(CMD_RDAS4))
                                     : cmd_onehot(CMD_RDA);
            else       dec_cmd = cmd_onehot(CMD_RD);
          end
          3'b110: dec_cmd = a[10] ? cmd_onehot(CMD_ZQCL) : cmd_onehot(CMD_ZQCS);
          default: begin
            dec_cmd   = cmd_onehot(CMD_NOP);
            dec_valid = 1'b0;
          end
        endcase
      end
    end
  end

  assign burst_load = (state == IDLE) && cke && cke_q && dec_rdwr;
  assign burst_adv  = (state == BURST) && !burst_last;

  burst_addr_gen #(
    .COLS (COLS),
    .BL   (BL)
  ) u_burst_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .halt      (halt),
    .load      (burst_load),
    .advance   (burst_adv),
    .bc4       (bc4),
    .start_col (a[$clog2(COLS)-1:0]),
    .column    (column),
    .last      (burst_last)
  );

  // Front-end state machine with registered outputs. CKE edges take priority
  // over the pin decode in IDLE; while busy, the only effect of a real
  // command is the cmd_drop pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      commands   <= '0;
      bg         <= '0;
      ba         <= '0;
      row        <= '0;
      busy       <= 1'b0;
      cmd_drop   <= 1'b0;
      sr_latched <= 1'b0;
      cke_q      <= 1'b1;
      ap_q       <= 1'b0;
    end else if (!halt) begin
      cke_q    <= cke;
      cmd_drop <= 1'b0;
      case (state)
        IDLE: begin
          commands <= '0;
          busy     <= 1'b0;
          if (cke_fall) begin
            commands <= dec_ref ? cmd_onehot(CMD_SRE) : cmd_onehot(CMD_PDE);
            if (dec_ref) sr_latched <= 1'b1;
          end else if (cke_rise) begin
            commands   <= sr_latched ? cmd_onehot(CMD_SRX) : cmd_onehot(CMD_PDX);
            sr_latched <= 1'b0;
          end else if (cke) begin
            commands <= dec_cmd;
            if (dec_valid) begin
              bg <= bg_in;
              ba <= ba_in;
            end
            if (dec_act) row <= ADDRWIDTH'(act_addr);
            if (dec_rdwr) begin
              state <= BURST;
              busy  <= 1'b1;
              ap_q  <= a[10];
            end
          end
        end
        BURST: begin
          if (dec_valid) cmd_drop <= 1'b1;
          if (burst_last) begin
            if (ap_q) begin
              state    <= AUTOPRE;
              commands <= cmd_onehot(CMD_PRE);
            end else begin
              state    <= IDLE;
              commands <= '0;
              busy     <= 1'b0;
            end
          end
        end
        AUTOPRE: begin
          if (dec_valid) cmd_drop <= 1'b1;
          state    <= IDLE;
          commands <= '0;
          busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          commands <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
